// File: rtl/spi_byte_slave.sv
// spi_byte_slave
//   SPI mode-0 slave byte transceiver for the SPI FPU command front end.
//   The SPI pins are oversampled in the clock domain (f_SCK <= f_clock/8).
//   MOSI is deserialised into bytes and response bytes are serialised onto MISO.
//   The FPU command state machine sees a byte-level valid/ready interface.
//
// Parameters
//   SYNC_STAGES  synchroniser depth on SCK, MOSI and nCS (min 2)
//   FILL_BYTE    byte shifted out when the controller offers nothing
//
// Ports
//   clock, reset         system clock, synchronous active-high reset
//   SPI_clock            SCK from master, idle low
//   SPI_in               MOSI
//   SPI_out              MISO, always driven, registered
//   SPI_not_chip_select  nCS, active low
//   in_data/_valid       last received byte, 1-cycle pulse on a new byte
//   out_data/_valid      response byte offered by the controller
//   out_data_ready       1-cycle pulse: out_data taken into the TX shifter
//   active               high while a frame is selected
//
// Configuration
//   SPI_BYTE_SLAVE_LSB_FIRST_EN  defined: LSB first on the wire for both
//                                directions; undefined: MSB first.
//
// State table
//   ST_IDLE       | not selected; MISO low, bit counter cleared, SCK ignored
//   ST_LOAD_FIRST | one cycle after cs_fall; loads the first TX byte
//   ST_SHIFT      | shifting bits on SCK edges
module spi_byte_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  FILL_BYTE   = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       SPI_clock,
  input  logic       SPI_in,
  output logic       SPI_out,
  input  logic       SPI_not_chip_select,
  output logic [7:0] in_data,
  output logic       in_data_valid,
  input  logic [7:0] out_data,
  input  logic       out_data_valid,
  output logic       out_data_ready,
  output logic       active
);

`ifdef SPI_BYTE_SLAVE_LSB_FIRST_EN
  localparam int TX_BIT = 0;
`else
  localparam int TX_BIT = 7;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_FIRST,
    ST_SHIFT
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, ncs_sync;
  logic sck_hist, ncs_hist;
  logic sck_s, mosi_s, ncs_s;
  logic sck_rise, sck_fall, cs_fall;

  // Synchronisers reset to 0: with nCS already low at reset release the
  // history never sees a 1->0 transition, so no frame starts until nCS toggles.
  always_ff @(posedge clock) begin
    if (reset) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      ncs_sync  <= '0;
      sck_hist  <= 1'b0;
      ncs_hist  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SPI_clock};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_in};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], SPI_not_chip_select};
      sck_hist  <= sck_sync[SYNC_STAGES-1];
      ncs_hist  <= ncs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign ncs_s    = ncs_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_hist;
  assign sck_fall = ~sck_s & sck_hist;
  assign cs_fall  = ~ncs_s & ncs_hist;

  state_t     state, state_n;
  logic [7:0] rx, rx_n, tx, tx_n;
  logic [7:0] rx_shifted, tx_shifted;
  logic [2:0] bit_count, bit_count_n;
  logic [7:0] in_data_n;
  logic       in_data_valid_n;
  logic       spi_out_n;
  logic       do_load;

`ifdef SPI_BYTE_SLAVE_LSB_FIRST_EN
  assign rx_shifted = {mosi_s, rx[7:1]};
  assign tx_shifted = {1'b0, tx[7:1]};
`else
  assign rx_shifted = {rx[6:0], mosi_s};
  assign tx_shifted = {tx[6:0], 1'b0};
`endif

  always_comb begin
    state_n         = state;
    rx_n            = rx;
    tx_n            = tx;
    bit_count_n     = bit_count;
    in_data_n       = in_data;
    in_data_valid_n = 1'b0;
    out_data_ready  = 1'b0;
    do_load         = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cs_fall) state_n = ST_LOAD_FIRST;
      end
      ST_LOAD_FIRST: begin
        if (ncs_s) begin
          state_n = ST_IDLE;
        end else begin
          do_load = 1'b1;
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // nCS deselect takes priority over a byte completing in the same cycle
        if (ncs_s) begin
          state_n = ST_IDLE;
        end else if (sck_rise) begin
          rx_n        = rx_shifted;
          bit_count_n = bit_count + 3'd1;
          if (bit_count == 3'd7) begin
            in_data_n       = rx_shifted;
            in_data_valid_n = 1'b1;
          end
        end else if (sck_fall) begin
          if (bit_count == 3'd0) do_load = 1'b1;
          else tx_n = tx_shifted;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Reloading on the falling edge after a byte gives the controller
    // several clocks after in_data_valid to offer its reply.
    if (do_load) begin
      if (out_data_valid) begin
        tx_n           = out_data;
        out_data_ready = 1'b1;
      end else begin
        tx_n = FILL_BYTE;
      end
    end

    if (state_n == ST_IDLE) begin
      bit_count_n = 3'd0;
      rx_n        = 8'h00;
      tx_n        = 8'h00;
    end

    spi_out_n = (state_n != ST_IDLE) ? tx_n[TX_BIT] : 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      rx            <= 8'h00;
      tx            <= 8'h00;
      bit_count     <= 3'd0;
      in_data       <= 8'h00;
      in_data_valid <= 1'b0;
      SPI_out       <= 1'b0;
    end else begin
      state         <= state_n;
      rx            <= rx_n;
      tx            <= tx_n;
      bit_count     <= bit_count_n;
      in_data       <= in_data_n;
      in_data_valid <= in_data_valid_n;
      SPI_out       <= spi_out_n;
    end
  end

  assign active = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_byte_slave.sv
// Testbench for spi_byte_slave: an SPI master driver, a reply-offering
// controller model and two scoreboards (received bytes, MISO bytes).
module tb_spi_byte_slave;
  localparam int H = 5;  // SCK half period in system clocks

  logic       clock = 1'b0;
  logic       reset;
  logic       sck, mosi, ncs, miso;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       active;

  always #5 clock = ~clock;

  spi_byte_slave dut (
    .clock              (clock),
    .reset              (reset),
    .SPI_clock          (sck),
    .SPI_in             (mosi),
    .SPI_out            (miso),
    .SPI_not_chip_select(ncs),
    .in_data            (in_data),
    .in_data_valid      (in_valid),
    .out_data           (out_data),
    .out_data_valid     (out_valid),
    .out_data_ready     (out_ready),
    .active             (active)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  logic [7:0] got_miso[$];

  // Frame plan shared by driver and controller model
  int         cur_n = 0;
  logic       cur_offer[4];
  logic [7:0] cur_reply[4];
  logic [7:0] cur_mosi[4];
  int         frame_id = 0;
  int         ready_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int wire_bit(input int b);
`ifdef SPI_BYTE_SLAVE_LSB_FIRST_EN
    return b;
`else
    return 7 - b;
`endif
  endfunction

  // Received-byte scoreboard
  initial begin
    forever begin
      @(negedge clock);
      if (in_valid === 1'b1) begin
        if (exp_rx.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: got in_data_valid with byte %0h, expected no byte", in_data);
        end else begin
          check("rx_byte", 32'(in_data), 32'(exp_rx.pop_front()));
        end
      end
    end
  end

  // MISO scoreboard
  initial begin
    forever begin
      @(negedge clock);
      if (got_miso.size() > 0) begin
        if (exp_miso.size() == 0) begin
          total++;
          bad++;
          $display("FAIL miso_unexpected: got byte %0h, expected none", got_miso.pop_front());
        end else begin
          check("miso_byte", 32'(got_miso.pop_front()), 32'(exp_miso.pop_front()));
        end
      end
    end
  end

  // Controller model: offers slot 0 before the frame starts, later slots a
  // few clocks after the previous byte arrives; withdraws on ready.
  initial begin
    int   seen_id;
    int   rx_seen;
    int   delay;
    int   pend;
    logic r, v;
    out_valid = 1'b0;
    out_data  = 8'h00;
    seen_id   = 0;
    rx_seen   = 0;
    delay     = -1;
    pend      = 0;
    forever begin
      @(negedge clock);
      r = out_ready;
      v = in_valid;
      @(posedge clock);
      #1;
      if (r === 1'b1) begin
        ready_cnt++;
        out_valid = 1'b0;
      end
      if (seen_id != frame_id) begin
        seen_id = frame_id;
        rx_seen = 0;
        delay   = -1;
        if (cur_n > 0 && cur_offer[0]) begin
          out_data  = cur_reply[0];
          out_valid = 1'b1;
        end
      end
      if (v === 1'b1) begin
        rx_seen++;
        if (rx_seen < cur_n && cur_offer[rx_seen]) begin
          pend  = rx_seen;
          delay = $urandom_range(0, 2);
        end
      end
      if (delay == 0) begin
        out_data  = cur_reply[pend];
        out_valid = 1'b1;
        delay     = -1;
      end else if (delay > 0) begin
        delay--;
      end
    end
  end

  task automatic send_bits(input logic [7:0] data, input int nbits, output logic [7:0] cap);
    cap = 8'h00;
    for (int b = 0; b < nbits; b++) begin
      mosi = data[wire_bit(b)];
      repeat (H) @(negedge clock);
      sck = 1'b1;
`ifdef SPI_BYTE_SLAVE_LSB_FIRST_EN
      cap = {miso, cap[7:1]};
`else
      cap = {cap[6:0], miso};
`endif
      repeat (H) @(negedge clock);
      sck = 1'b0;
    end
  endtask

  // n full bytes from cur_mosi, then tail_bits of tail_data before nCS rises
  task automatic run_frame(input int n, input int tail_bits, input logic [7:0] tail_data);
    int         r0;
    int         offers;
    logic [7:0] cap;
    offers = 0;
    cur_n  = n;
    for (int k = 0; k < n; k++) begin
      exp_rx.push_back(cur_mosi[k]);
      exp_miso.push_back(cur_offer[k] ? cur_reply[k] : 8'h00);
      if (cur_offer[k]) offers++;
    end
    frame_id++;
    r0 = ready_cnt;
    repeat (3) @(negedge clock);
    ncs = 1'b0;
    repeat (8) @(negedge clock);
    check("active_in_frame", 32'(active), 32'd1);
    for (int k = 0; k < n; k++) begin
      send_bits(cur_mosi[k], 8, cap);
      got_miso.push_back(cap);
    end
    if (tail_bits > 0) send_bits(tail_data, tail_bits, cap);
    repeat (H) @(negedge clock);
    ncs = 1'b1;
    repeat (8) @(negedge clock);
    check("ready_pulses", 32'(ready_cnt - r0), 32'(offers));
    check("active_after_frame", 32'(active), 32'd0);
  endtask

  task automatic plan(input int k, input logic [7:0] tx_byte, input logic offer, input logic [7:0] reply);
    cur_mosi[k]  = tx_byte;
    cur_offer[k] = offer;
    cur_reply[k] = reply;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_data"}, 32'(in_data), 32'd0);
    check({tag, "_in_valid"}, 32'(in_valid), 32'd0);
    check({tag, "_out_ready"}, 32'(out_ready), 32'd0);
    check({tag, "_active"}, 32'(active), 32'd0);
    check({tag, "_miso"}, 32'(miso), 32'd0);
  endtask

  initial begin
    logic [7:0] cap;
    int         n;
    for (int k = 0; k < 4; k++) plan(k, 8'h00, 1'b0, 8'h00);
    reset = 1'b1;
    sck   = 1'b0;
    mosi  = 1'b0;
    ncs   = 1'b1;
    repeat (4) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (6) @(negedge clock);

    // Single byte, nothing offered
    plan(0, 8'hA5, 1'b0, 8'h00);
    run_frame(1, 0, 8'h00);
    check("in_data_hold", 32'(in_data), 32'hA5);

    // Reply offered before the frame starts
    plan(0, 8'h00, 1'b1, 8'h3C);
    run_frame(1, 0, 8'h00);

    // Two bytes, no reply at all
    plan(0, 8'h12, 1'b0, 8'h00);
    plan(1, 8'h34, 1'b0, 8'h00);
    run_frame(2, 0, 8'h00);

    // Back-to-back, reply offered after the first byte arrives
    plan(0, 8'h01, 1'b0, 8'h00);
    plan(1, 8'hFE, 1'b1, 8'h77);
    run_frame(2, 0, 8'h00);

    // Partial byte discarded, next frame aligned
    run_frame(0, 5, 8'hFF);
    plan(0, 8'h5A, 1'b0, 8'h00);
    run_frame(1, 0, 8'h00);

    // Reset mid-transfer with nCS held low
    cur_n = 0;
    frame_id++;
    repeat (3) @(negedge clock);
    ncs = 1'b0;
    repeat (8) @(negedge clock);
    send_bits(8'hC3, 4, cap);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_reset_outputs("midreset");
    send_bits(8'h3C, 8, cap);
    repeat (H) @(negedge clock);
    check("active_no_restart", 32'(active), 32'd0);
    ncs = 1'b1;
    repeat (8) @(negedge clock);
    plan(0, 8'hC3, 1'b1, 8'h96);
    run_frame(1, 0, 8'h00);

    // Randomised frames
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++)
        plan(k, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      run_frame(n, 0, 8'h00);
    end

    repeat (10) @(negedge clock);
    check("rx_all_received", 32'(exp_rx.size()), 32'd0);
    check("miso_all_checked", 32'(exp_miso.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
